dual_grant_decoder: RTL and testbench
=====================================

DUAL_GRANT_DECODER -- requirements
Module: dual_grant_decoder

Interface
REQ-001 The block SHALL have parameter N, default 12, giving the number of requesters and the grant vector width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles one grant is held without ack.
REQ-003 The block SHALL use W = $clog2(N) as the index width.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: load  input  1  request to accept a new index pair.
REQ-007 Port: first  input  W  highest-priority requester index.
REQ-008 Port: first_valid  input  1  first is meaningful.
REQ-009 Port: second  input  W  second-priority requester index.
REQ-010 Port: second_valid  input  1  second is meaningful.
REQ-011 Port: ack  input  1  the granted requester has finished.
REQ-012 Port: ready  output  1  block is idle and accepts load.
REQ-013 Port: grant  output  N  one-hot grant vector, all zero when not granting.
REQ-014 Port: grant_valid  output  1  grant holds exactly one set bit.
REQ-015 Port: timeout  output  1  one-cycle pulse when a grant is dropped for lack of ack.
REQ-016 Port: err  output  1  one-cycle pulse when a load carried an out-of-range valid index.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GRANT_FIRST and GRANT_SECOND.
REQ-018 ready SHALL be 1 only in IDLE, and grant_valid SHALL be 1 only in the two GRANT states.
REQ-019 An index SHALL be usable when its valid bit is 1 and its value is < N.
REQ-020 A second index equal to a usable first index SHALL be treated as not usable.
REQ-021 When load=1 and ready=1 at an edge, the block SHALL latch both indices and their usability in the same edge.
REQ-022 On that accepting edge, the FSM SHALL go to GRANT_FIRST if first is usable, else to GRANT_SECOND if second is usable, else remain in IDLE.
REQ-023 Grant latency from the accepting edge SHALL be one cycle, so grant appears in the cycle after load is sampled.
REQ-024 load while ready=0 SHALL be ignored, with no latch, no err and no state change.
REQ-025 err SHALL pulse for one cycle after an accepted load in which either valid bit was 1 with an index >= N.
REQ-026 In a GRANT state, grant SHALL be the one-hot bit of the latched index for that state.
REQ-027 An edge with ack=1 in GRANT_FIRST SHALL move the FSM to GRANT_SECOND if the second index is usable, else to IDLE.
REQ-028 A GRANT_FIRST to GRANT_SECOND transition SHALL keep grant_valid=1 with no gap between grants.
REQ-029 An edge with ack=1 in GRANT_SECOND SHALL move the FSM to IDLE.
REQ-030 ack in IDLE SHALL be ignored.
REQ-031 A hold counter SHALL clear on every entry to a GRANT state and increment each granting cycle without ack.
REQ-032 If ack=0 at an edge where the counter equals TIMEOUT-1, the block SHALL end that grant exactly as an ack would.
REQ-033 A grant ended by REQ-032 SHALL pulse timeout for the following cycle.
REQ-034 ack=1 on the expiry edge SHALL take precedence, with no timeout pulse.
REQ-035 The counter SHALL be wide enough for TIMEOUT-1 and SHALL never wrap while granting.
REQ-036 grant SHALL never have more than one bit set.

Reset
REQ-037 While rst=1, the state SHALL be IDLE, with ready=1, grant=0, grant_valid=0, timeout=0, err=0, the counter at 0 and latched indices cleared.
REQ-038 Reset assertion mid-grant SHALL drop grant immediately, without waiting for a clock edge.
REQ-039 After reset release, the first accepted load SHALL behave as a fresh transaction, with no pending second index.

Verification
REQ-040 Bench: load with first=3 and second=7, both valid; ack after 2 cycles, then ack again -> grant=0x008 for 2 cycles, then 0x080 with no gap, then ready=1.
REQ-041 Bench: load with first=5 valid and second invalid; no ack for 16 cycles -> grant=0x020 for 16 cycles, then a one-cycle timeout pulse, then IDLE.
REQ-042 Bench: load with first=11 and second=11, both valid; ack -> grant=0x800 only, and ready=1 after the single ack.
REQ-043 Bench: load with first=13 valid and second=2 valid -> err pulses for one cycle and grant=0x004 directly.
REQ-044 Bench: raise load while grant_valid=1, then assert rst mid-grant -> the load is ignored, grant=0 immediately, and ready=1.
REQ-045 Bench: ack on the expiry edge (cycle 16) -> no timeout pulse, and normal advance.

Source files
------------

// File: rtl/dual_grant_decoder.sv
// dual_grant_decoder: grants up to two requesters in priority order, one at a time.
// Holds each grant until ack or until TIMEOUT cycles pass, then moves on.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   load         accept a new index pair (only honoured while ready)
//   first        highest-priority requester index
//   first_valid  first is meaningful
//   second       second-priority requester index
//   second_valid second is meaningful
//   ack          granted requester has finished
//   ready        idle, a load will be accepted
//   grant        one-hot grant vector, zero when not granting
//   grant_valid  grant holds exactly one set bit
//   timeout      one-cycle pulse after a grant is dropped for lack of ack
//   err          one-cycle pulse after an accepted load had a bad valid index
module dual_grant_decoder #(
  parameter int N       = 12,
  parameter int TIMEOUT = 16,
  localparam int W  = (N > 1) ? $clog2(N) : 1,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] first,
  input  logic         first_valid,
  input  logic [W-1:0] second,
  input  logic         second_valid,
  input  logic         ack,
  output logic         ready,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic         timeout,
  output logic         err
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [W:0]    NLIM = (W+1)'(N);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_FIRST,
    GRANT_SECOND
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [W-1:0]  f_q;
  logic [W-1:0]  s_q;
  logic          s_ok_q;
  logic [CW-1:0] cnt_q;
  logic          to_q;
  logic          err_q;

  logic          f_rng;
  logic          s_rng;
  logic          f_use;
  logic          s_use;
  logic          bad;
  logic          accept;
  logic          granting;
  logic          expire;
  logic          hold_end;
  logic [W-1:0]  idx;

  // Index qualification on the incoming pair.
  always_comb begin
    f_rng  = {1'b0, first} < NLIM;
    s_rng  = {1'b0, second} < NLIM;
    f_use  = first_valid && f_rng;
    // A duplicate of a usable first would grant the same requester twice.
    s_use  = second_valid && s_rng &&
             !(f_use && (second == first));
    bad    = (first_valid && !f_rng) ||
             (second_valid && !s_rng);
  end

  always_comb begin
    accept   = load && (state == IDLE);
    granting = (state != IDLE);
    // Ack wins over expiry on the same edge.
    expire   = granting && !ack && (cnt_q == CMAX);
    hold_end = granting && (ack || (cnt_q == CMAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (f_use) begin
            state_nx = GRANT_FIRST;
          end else if (s_use) begin
            state_nx = GRANT_SECOND;
          end
        end
      end
      GRANT_FIRST: begin
        if (hold_end) begin
          state_nx = s_ok_q ? GRANT_SECOND
                            : IDLE;
        end
      end
      GRANT_SECOND: begin
        if (hold_end) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Index pair is latched on every accepting edge, usable or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_q    <= '0;
      s_q    <= '0;
      s_ok_q <= 1'b0;
    end else if (accept) begin
      f_q    <= first;
      s_q    <= second;
      s_ok_q <= s_use;
    end
  end

  // Hold counter: zero outside grants and on every grant change,
  // so it restarts on each entry and stops at CMAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!granting || hold_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      to_q  <= expire;
      err_q <= accept && bad;
    end
  end

  // Outputs decode from state only, so reset clears them at once.
  always_comb begin
    idx = (state == GRANT_SECOND) ? s_q : f_q;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = granting && (idx == W'(i));
    end
  end

  assign ready       = (state == IDLE);
  assign grant_valid = granting;
  assign timeout     = to_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dual_grant_decoder.sv
// tb_dual_grant_decoder: directed table, hand sequences and a
// random run against a queue-based reference model.
module tb_dual_grant_decoder;

  localparam int NN  = 12;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [3:0]  first = '0;
  logic        first_valid = 1'b0;
  logic [3:0]  second = '0;
  logic        second_valid = 1'b0;
  logic        ack = 1'b0;
  logic        ready;
  logic [11:0] grant;
  logic        grant_valid;
  logic        timeout;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_grant_decoder #(.N(NN), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .first(first),
    .first_valid(first_valid),
    .second(second),
    .second_valid(second_valid),
    .ack(ack),
    .ready(ready),
    .grant(grant),
    .grant_valid(grant_valid),
    .timeout(timeout),
    .err(err)
  );

  typedef struct {
    logic        ld;
    logic [3:0]  f;
    logic        fv;
    logic [3:0]  s;
    logic        sv;
    logic        a;
    logic        rdy;
    logic [11:0] gnt;
    logic        gv;
    logic        to;
    logic        er;
  } vec_t;

  vec_t tbl[$];

  // Reference model: queue of requesters still to be granted.
  int mq[$];
  int mhold;
  bit mto;
  bit merr;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(string tag, logic erdy,
                         logic [11:0] egnt, logic egv,
                         logic eto, logic eerr);
    chk({tag, ".ready"}, int'(ready), int'(erdy));
    chk({tag, ".grant"}, int'(grant), int'(egnt));
    chk({tag, ".grant_valid"}, int'(grant_valid), int'(egv));
    chk({tag, ".timeout"}, int'(timeout), int'(eto));
    chk({tag, ".err"}, int'(err), int'(eerr));
  endtask

  task automatic drv(logic ld, logic [3:0] f, logic fv,
                     logic [3:0] s, logic sv, logic a);
    @(negedge clk);
    load = ld;
    first = f;
    first_valid = fv;
    second = s;
    second_valid = sv;
    ack = a;
    #1;
  endtask

  task automatic m_reset();
    mq.delete();
    mhold = 0;
    mto = 1'b0;
    merr = 1'b0;
  endtask

  task automatic m_edge(bit ld, int f, bit fv,
                        int s, bit sv, bit a);
    bit nto;
    bit nerr;
    bit fu;
    bit su;
    nto = 1'b0;
    nerr = 1'b0;
    if (mq.size() == 0) begin
      if (ld) begin
        fu = fv && (f < NN);
        su = sv && (s < NN) && !(fu && (s == f));
        if (fu) mq.push_back(f);
        if (su) mq.push_back(s);
        nerr = (fv && f >= NN) || (sv && s >= NN);
        mhold = 0;
      end
    end else if (a) begin
      void'(mq.pop_front());
      mhold = 0;
    end else if (mhold == TMO - 1) begin
      void'(mq.pop_front());
      mhold = 0;
      nto = 1'b1;
    end else begin
      mhold++;
    end
    mto = nto;
    merr = nerr;
  endtask

  initial begin
    // Two back-to-back grants with acks.
    tbl.push_back('{1, 3, 1, 7, 1, 0, 1, 12'h000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'h008, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'h008, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 12'h080, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'h080, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0});
    // Duplicate second collapses to a single grant.
    tbl.push_back('{1, 11, 1, 11, 1, 0, 1, 12'h000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'h800, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0});
    // Out-of-range first: err and direct second grant.
    tbl.push_back('{1, 13, 1, 2, 1, 0, 1, 12'h000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 12'h004, 1, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0});
    // Ack in idle ignored; invalid pair stays idle, no err.
    tbl.push_back('{0, 0, 0, 0, 0, 1, 1, 12'h000, 0, 0, 0});
    tbl.push_back('{1, 12, 0, 15, 0, 0, 1, 12'h000, 0, 0, 0});
    tbl.push_back('{1, 14, 1, 0, 0, 0, 1, 12'h000, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 12'h000, 0, 0, 0});

    // Reset state, checked while rst is held.
    #1;
    chk_out("reset", 1, 12'h000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drv(tbl[i].ld, tbl[i].f, tbl[i].fv,
          tbl[i].s, tbl[i].sv, tbl[i].a);
      chk_out($sformatf("tbl%0d", i), tbl[i].rdy,
              tbl[i].gnt, tbl[i].gv, tbl[i].to, tbl[i].er);
    end

    // Full timeout on first with no second.
    drv(1, 5, 1, 0, 0, 0);
    for (int c = 1; c <= TMO; c++) begin
      drv(0, 0, 0, 0, 0, 0);
      chk_out($sformatf("tmo_c%0d", c), 0, 12'h020, 1, 0, 0);
    end
    drv(0, 0, 0, 0, 0, 0);
    chk_out("tmo_pulse", 1, 12'h000, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_out("tmo_after", 1, 12'h000, 0, 0, 0);

    // Ack on the expiry edge: normal advance, no pulse.
    drv(1, 5, 1, 7, 1, 0);
    for (int c = 1; c < TMO; c++) begin
      drv(0, 0, 0, 0, 0, 0);
    end
    drv(0, 0, 0, 0, 0, 1);
    chk_out("exp_ack", 0, 12'h020, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_out("exp_next", 0, 12'h080, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    chk_out("exp_last", 0, 12'h080, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_out("exp_idle", 1, 12'h000, 0, 0, 0);

    // Load during grant ignored, then reset mid-grant.
    drv(1, 3, 1, 7, 1, 0);
    drv(1, 13, 1, 5, 1, 0);
    chk_out("busy_ld", 0, 12'h008, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_out("busy_after", 0, 12'h008, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1, 12'h000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    // Fresh transaction: no stale second after the ack.
    drv(1, 4, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1);
    chk_out("fresh_g", 0, 12'h010, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_out("fresh_idle", 1, 12'h000, 0, 0, 0);

    // Randomized run against the model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] eg;
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 1) == 1);
      first = 4'($urandom_range(0, 15));
      first_valid = ($urandom_range(0, 3) != 0);
      second = 4'($urandom_range(0, 15));
      second_valid = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 7) == 0);
      #1;
      if (rst) m_reset();
      eg = (mq.size() != 0) ? 12'(1 << mq[0]) : 12'h000;
      chk_out($sformatf("rnd%0d", n), mq.size() == 0, eg,
              mq.size() != 0, mto, merr);
      @(posedge clk);
      if (!rst) begin
        m_edge(load, int'(first), first_valid,
               int'(second), second_valid, ack);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
